// File: rtl/mult_unit_if.sv
// Handshake and result bus between the MIPS operand path and the HI/LO multiplier.
// The pipeline drives the master side; mult_unit sits on the slave side.
interface mult_unit_if;
  logic        start;
  logic        is_signed;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, is_signed, op_a, op_b, mthi, mtlo, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, is_signed, op_a, op_b, mthi, mtlo, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_unit.sv
// Sequential 32x32 shift-and-add multiplier owning the HI/LO registers (MULT/MULTU,
// MTHI/MTLO), built around 32-bit ripple adders.

module ripple_add32 #(
  parameter logic CARRY_IN_0 = 1'b0
) (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum,
  output logic        cout
);
  logic carry;

  always_comb begin
    carry = CARRY_IN_0;
    sum   = '0;
    for (int i = 0; i < 32; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end
endmodule

// state | meaning
// IDLE  | waiting; accepts start / mthi / mtlo
// CALC  | 32 shift-and-add iterations on {hi,lo}
// SIGN  | optional 64-bit negate of the product
// DONE  | one-cycle result pulse; accepts like IDLE
module mult_unit (
  input  logic        clk,
  input  logic        rst,
  mult_unit_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q;
  logic [31:0] mcand_q;
  logic [31:0] hi_q, lo_q;
  logic        neg_q;

  logic        accept;
  logic [31:0] neg_a, neg_b, mag_a, mag_b;
  logic [31:0] step_b, step_sum;
  logic        step_c;
  logic [31:0] neg_lo, neg_hi;
  logic        neg_k;
  logic        unused_ca, unused_cb, unused_chi;

  assign accept = (state_q == IDLE) || (state_q == DONE);

  // Magnitudes are ~x + 1 with a zero b operand
  ripple_add32 #(.CARRY_IN_0(1'b1)) u_mag_a (
    .a(~bus.op_a), .b(32'd0), .sum(neg_a), .cout(unused_ca)
  );
  ripple_add32 #(.CARRY_IN_0(1'b1)) u_mag_b (
    .a(~bus.op_b), .b(32'd0), .sum(neg_b), .cout(unused_cb)
  );

  assign mag_a = (bus.is_signed && bus.op_a[31]) ? neg_a : bus.op_a;
  assign mag_b = (bus.is_signed && bus.op_b[31]) ? neg_b : bus.op_b;

  assign step_b = lo_q[0] ? mcand_q : 32'd0;

  ripple_add32 #(.CARRY_IN_0(1'b0)) u_step (
    .a(hi_q), .b(step_b), .sum(step_sum), .cout(step_c)
  );

  ripple_add32 #(.CARRY_IN_0(1'b1)) u_neg_lo (
    .a(~lo_q), .b(32'd0), .sum(neg_lo), .cout(neg_k)
  );
  ripple_add32 #(.CARRY_IN_0(1'b0)) u_neg_hi (
    .a(~hi_q), .b({31'd0, neg_k}), .sum(neg_hi), .cout(unused_chi)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = CALC;
      CALC:    if (cnt_q == 5'd31) state_d = SIGN;
      SIGN:    state_d = DONE;
      DONE:    state_d = bus.start ? CALC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      neg_q   <= 1'b0;
    end else if (accept) begin
      // start wins over a simultaneous move
      if (bus.start) begin
        mcand_q <= mag_b;
        lo_q    <= mag_a;
        hi_q    <= '0;
        cnt_q   <= '0;
        neg_q   <= bus.is_signed & (bus.op_a[31] ^ bus.op_b[31]);
      end else begin
        if (bus.mthi) hi_q <= bus.wdata;
        if (bus.mtlo) lo_q <= bus.wdata;
      end
    end else if (state_q == CALC) begin
      hi_q  <= {step_c, step_sum[31:1]};
      lo_q  <= {step_sum[0], lo_q[31:1]};
      cnt_q <= cnt_q + 5'd1;
    end else if (state_q == SIGN && neg_q) begin
      hi_q <= neg_hi;
      lo_q <= neg_lo;
    end
  end

  assign bus.busy = (state_q == CALC) || (state_q == SIGN);
  assign bus.done = (state_q == DONE);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit: directed corner cases plus randomized
// MULT/MULTU/MTHI/MTLO traffic against a 64-bit arithmetic reference.
module tb_mult_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always #5 clk = ~clk;

  mult_unit_if bus();

  mult_unit u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [63:0] ea, eb;
    ea = s ? {{32{a[31]}}, a} : {32'd0, a};
    eb = s ? {{32{b[31]}}, b} : {32'd0, b};
    return ea * eb;
  endfunction

  task automatic clear_inputs();
    bus.start = 1'b0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
  endtask

  // caller is at a negedge; drives the start request for the next posedge
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    bus.start     = 1'b1;
    bus.is_signed = s;
    bus.op_a      = a;
    bus.op_b      = b;
    {m_hi, m_lo}  = ref_prod(a, b, s);
  endtask

  task automatic wait_done(output int lat);
    @(negedge clk);
    clear_inputs();
    check("busy_after_start", {63'd0, bus.busy}, 64'd1);
    lat = 1;
    while (!bus.done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s);
    int lat;
    start_op(a, b, s);
    wait_done(lat);
    check({tag, "_lat"}, 64'(lat), 64'd34);
    check({tag, "_prod"}, {bus.hi, bus.lo}, {m_hi, m_lo});
    check({tag, "_busy"}, {63'd0, bus.busy}, 64'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'd0;
      3: return 32'(  $urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat;
    clear_inputs();
    bus.is_signed = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
    bus.wdata = '0;
    repeat (2) @(negedge clk);
    check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    check("reset_flags", {62'd0, bus.busy, bus.done}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("multu_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("multu_max_abs", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
    run_op("mult_m2x3", 32'hFFFF_FFFE, 32'h0000_0003, 1'b1);
    check("mult_m2x3_abs", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op("mult_m1xm1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    check("mult_m1xm1_abs", {bus.hi, bus.lo}, 64'h0000_0000_0000_0001);
    run_op("mult_minxmin", 32'h8000_0000, 32'h8000_0000, 1'b1);
    check("mult_minxmin_abs", {bus.hi, bus.lo}, 64'h4000_0000_0000_0000);
    run_op("mult_minx1", 32'h8000_0000, 32'h0000_0001, 1'b1);
    check("mult_minx1_abs", {bus.hi, bus.lo}, 64'hFFFF_FFFF_8000_0000);
    run_op("multu_minx2", 32'h8000_0000, 32'h0000_0002, 1'b0);
    check("multu_minx2_abs", {bus.hi, bus.lo}, 64'h0000_0001_0000_0000);

    // requests during CALC must vanish
    @(negedge clk);
    check("done_one_cycle", {63'd0, bus.done}, 64'd0);
    start_op(32'd5, 32'd7, 1'b0);
    @(negedge clk);
    clear_inputs();
    lat = 1;
    while (!bus.done && lat < 100) begin
      if (lat == 10) begin
        bus.start = 1'b1; bus.op_a = 32'd9; bus.op_b = 32'd9;
        bus.mthi = 1'b1; bus.wdata = 32'hDEAD_BEEF;
      end
      @(negedge clk);
      clear_inputs();
      lat++;
    end
    check("busy_prot_lat", 64'(lat), 64'd34);
    check("busy_prot_prod", {bus.hi, bus.lo}, 64'd35);
    @(negedge clk);
    bus.mtlo = 1'b1; bus.wdata = 32'h1234_5678;
    @(negedge clk);
    clear_inputs();
    m_lo = 32'h1234_5678;
    check("mtlo_idle", {bus.hi, bus.lo}, {32'd0, 32'h1234_5678});

    // asynchronous reset in the middle of an operation
    start_op(32'hFFFF_FF00, 32'd77, 1'b1);
    @(negedge clk);
    clear_inputs();
    repeat (19) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_hilo", {bus.hi, bus.lo}, 64'd0);
    check("midrst_flags", {62'd0, bus.busy, bus.done}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op("after_rst", 32'd3, 32'd4, 1'b0);
    check("after_rst_abs", {bus.hi, bus.lo}, 64'd12);

    // back-to-back start in DONE with a simultaneous, dropped mthi
    start_op(32'd6, 32'd7, 1'b0);
    bus.mthi = 1'b1; bus.wdata = 32'hFFFF_0000;
    wait_done(lat);
    check("b2b_lat", 64'(lat), 64'd34);
    check("b2b_prod", {bus.hi, bus.lo}, 64'd42);

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clk);
        bus.mthi = 1'($urandom_range(0, 1));
        bus.mtlo = 1'($urandom_range(0, 1));
        bus.wdata = $urandom;
        if (bus.mthi) m_hi = bus.wdata;
        if (bus.mtlo) m_lo = bus.wdata;
        @(negedge clk);
        clear_inputs();
        check("rnd_move", {bus.hi, bus.lo}, {m_hi, m_lo});
      end
      run_op("rnd_op", pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    check("final_hold", {bus.hi, bus.lo}, {m_hi, m_lo});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
